// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory: assembles little-endian words and writes them sequentially.
// Optional trailing 8-bit checksum byte when CHECKSUM_EN is defined.
module imem_loader #(
  parameter int NUM_INSTR = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA,
`ifdef CHECKSUM_EN
    CSUM,
`endif
    DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(NUM_INSTR);

  state_t      state, nstate;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] widx;
  logic [1:0]  bcnt;
  logic [23:0] word;
  logic        xfer;
  logic        start_ok;
  logic        last_word;
  logic [15:0] len_full;

`ifdef CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] csum_total;
  assign csum_total = sum + byte_data;
`endif

  assign xfer      = byte_valid & byte_ready;
  assign len_full  = {byte_data, len_lo};
  assign last_word = (widx == len - 16'd1);
  assign start_ok  = start & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign cpu_hold  = (state != DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate     = state;
    byte_ready = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) nstate = LEN0;
      end
      LEN0: begin
        byte_ready = 1'b1;
        if (xfer) nstate = LEN1;
      end
      LEN1: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (len_full == 16'd0)
`ifdef CHECKSUM_EN
            nstate = CSUM;
`else
            nstate = DONE;
`endif
          else if ({1'b0, len_full} > MAX_LEN) nstate = ERR;
          else                                 nstate = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        // The final word's write strobe fires in the first cycle of the next state.
        if (xfer && bcnt == 2'd3 && last_word)
`ifdef CHECKSUM_EN
          nstate = CSUM;
`else
          nstate = DONE;
`endif
      end
`ifdef CHECKSUM_EN
      CSUM: begin
        byte_ready = 1'b1;
        if (xfer) nstate = (csum_total == 8'd0) ? DONE : ERR;
      end
`endif
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      len_lo <= '0;
      len    <= '0;
      widx   <= '0;
      bcnt   <= '0;
      word   <= '0;
`ifdef CHECKSUM_EN
      sum    <= '0;
`endif
    end else begin
      we <= 1'b0;
      if (start_ok) begin
        widx <= '0;
        bcnt <= '0;
`ifdef CHECKSUM_EN
        sum  <= '0;
`endif
      end
      if (state == LEN0 && xfer) len_lo <= byte_data;
      if (state == LEN1 && xfer) len    <= len_full;
      if (state == DATA && xfer) begin
        bcnt <= bcnt + 2'd1;
`ifdef CHECKSUM_EN
        sum  <= csum_total;
`endif
        if (bcnt == 2'd3) begin
          we    <= 1'b1;
          wdata <= {byte_data, word};
          waddr <= widx[ADDR_W-1:0];
          widx  <= widx + 16'd1;
        end else begin
          word[{bcnt, 3'b000} +: 8] <= byte_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; follows CHECKSUM_EN when defined.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        n_rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, we, cpu_hold, done, error;
  logic [9:0]  waddr;
  logic [31:0] wdata;

  imem_loader #(.NUM_INSTR(1024), .ADDR_W(10)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1) begin
        if (we === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_we: waddr=%0h wdata=%0h, no write expected", waddr, wdata);
          end else begin
            e = exp_q.pop_front();
            chk("waddr", 64'(waddr), 64'(e.a));
            chk("wdata", 64'(wdata), 64'(e.d));
          end
        end
        chk("done_error_exclusive", 64'(done & error), 64'd0);
        chk("cpu_hold_vs_done", 64'(cpu_hold), 64'(!done));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    bit ok = 0;
    byte_valid = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL byte_ready_timeout: byte_ready=%b expected 1", byte_ready);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  // Reference: a frame of n words is written to addresses 0..n-1 unless n exceeds depth.
  task automatic run_frame(input int n, input int smin, input int smax, input bit bad_c);
    logic [7:0]  sum = 8'd0;
    logic [7:0]  b;
    logic [15:0] nl = 16'(n);
    bit          ovf = (n > 1024);
    bit          exp_ok = !ovf;
    bit          seen = 0;
    if (!ovf)
      for (int i = 0; i < n; i++) exp_q.push_back({10'(i), img[i]});
    pulse_start();
    send_byte(nl[7:0],  $urandom_range(smax, smin));
    send_byte(nl[15:8], $urandom_range(smax, smin));
    if (!ovf) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) begin
          b   = img[i][8*k +: 8];
          sum = sum + b;
          send_byte(b, $urandom_range(smax, smin));
        end
`ifdef CHECKSUM_EN
      b = 8'd0 - sum + (bad_c ? 8'd1 : 8'd0);
      send_byte(b, $urandom_range(smax, smin));
      exp_ok = !bad_c;
`endif
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) begin seen = 1; break; end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL frame_timeout n=%0d: done=%b error=%b expected one set", n, done, error);
    end
    @(negedge clk);
    chk("done",          64'(done),         64'(exp_ok));
    chk("error",         64'(error),        64'(!exp_ok));
    chk("cpu_hold_end",  64'(cpu_hold),     64'(!exp_ok));
    chk("byte_ready_end", 64'(byte_ready),  64'd0);
    chk("writes_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"},         64'(we),         64'd0);
    chk({tag, "_waddr"},      64'(waddr),      64'd0);
    chk({tag, "_wdata"},      64'(wdata),      64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
    chk({tag, "_error"},      64'(error),      64'd0);
    chk({tag, "_cpu_hold"},   64'(cpu_hold),   64'd1);
    chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    int n;
    n_rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    img.delete();
    img.push_back(32'h00A00513);
    img.push_back(32'h00B00593);
    run_frame(2, 0, 0, 0);
    run_frame(2, 3, 3, 0);
    run_frame(1025, 0, 1, 0);
    run_frame(0, 0, 1, 0);
`ifdef CHECKSUM_EN
    run_frame(2, 0, 0, 1);
    run_frame(2, 0, 1, 0);
`endif

    // Reset in the middle of a word: no write may escape.
    fill_img(2);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    send_byte(8'h33, 0);
    n_rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midload");
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_we",         64'(we),         64'd0);
    chk("post_reset_byte_ready", 64'(byte_ready), 64'd0);
    @(posedge clk); #1;

    for (int it = 0; it < 24; it++) begin
      if (it % 8 == 7) n = 1025 + $urandom_range(0, 3000);
      else             n = $urandom_range(0, 6);
      fill_img(n > 1024 ? 0 : n);
      run_frame(n, 0, 2, ($urandom_range(0, 3) == 0));
    end

    fill_img(1024);
    run_frame(1024, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
